// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage and the decode stage.
package fetch_stage_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0;
  localparam logic [31:0] WORD_BYTES   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch packet FIFO with flush; an empty queue passes a push straight to the head.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  output fetch_pkt_t    head_pkt,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  fetch_pkt_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          empty, bypass, do_wr, do_rd;

  assign empty      = (count == '0);
  assign head_valid = ~empty | push;
  assign head_pkt   = empty ? push_pkt : mem[rd_ptr];
  assign bypass     = empty & push & pop;
  assign do_wr      = push & ~bypass;
  assign do_rd      = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= push_pkt;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited requests, queues in-order
// responses and feeds decode under stall/redirect control.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4,
  output logic        instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, discard, occupancy;
  logic [CW:0]   credit;
  logic          req_fire, drop, accept, q_pop, head_valid;
  fetch_pkt_t    resp_pkt, head_pkt;

  assign credit    = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req  = ~reset & ~redirect & (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign req_fire  = imem_req & imem_gnt;
  assign drop      = imem_rvalid & (discard != '0);
  assign accept    = imem_rvalid & ~drop & ~redirect;
  assign resp_pkt  = '{instr: imem_rdata, pc: resp_pc};
  assign q_pop     = ~stall & ~redirect;

  fetch_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (accept),
    .push_pkt   (resp_pkt),
    .pop        (q_pop),
    .head_pkt   (head_pkt),
    .head_valid (head_valid),
    .count      (occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        // Everything still in flight after this edge is stale (no grant can
        // coincide: the request is masked during redirect).
        discard  <= outstanding - CW'(imem_rvalid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WORD_BYTES;
        if (accept)   resp_pc  <= resp_pc + WORD_BYTES;
        if (drop)     discard  <= discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr           <= BUBBLE_INSTR;
      instr_pc        <= '0;
      instr_pc_plus_4 <= '0;
      instr_valid     <= 1'b0;
    end else if (redirect || (!stall && !head_valid)) begin
      instr           <= BUBBLE_INSTR;
      instr_pc        <= '0;
      instr_pc_plus_4 <= '0;
      instr_valid     <= 1'b0;
    end else if (!stall) begin
      instr           <= head_pkt.instr;
      instr_pc        <= head_pkt.pc;
      instr_pc_plus_4 <= head_pkt.pc + WORD_BYTES;
      instr_valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: variable-latency memory model plus program-order stream checker.
module tb_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, instr_pc, instr_pc_plus_4;
  logic        instr_valid;

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4),
    .instr_valid     (instr_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: in-order responses, each ready a random number of cycles after grant.
  typedef struct { logic [31:0] addr; int ready; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  int    lat_min = 0, lat_max = 0, gnt_pct = 100;
  int    nvalid = 0;
  logic  last_req;

  // Reference: valid outputs form a +4 program-order stream restarting at each redirect target.
  logic [31:0] exp_pc;
  logic [31:0] p_instr, p_pc, p_pc4;
  logic        p_valid;

  task automatic monitor(input logic st, input logic rd, input logic [31:0] rpc);
    if (rd) begin
      check("redirect_valid", 32'(instr_valid), 32'd0);
      check("redirect_instr", instr, 32'h0);
      check("redirect_pc", instr_pc, 32'h0);
      exp_pc = rpc;
    end else if (st) begin
      check("stall_hold_valid", 32'(instr_valid), 32'(p_valid));
      check("stall_hold_pc", instr_pc, p_pc);
      check("stall_hold_instr", instr, p_instr);
      check("stall_hold_pc4", instr_pc_plus_4, p_pc4);
    end else if (instr_valid) begin
      check("stream_pc", instr_pc, exp_pc);
      check("stream_instr", instr, exp_pc >> 2);
      check("stream_pc4", instr_pc_plus_4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      nvalid++;
    end else begin
      check("bubble_instr", instr, 32'h0);
      check("bubble_pc", instr_pc, 32'h0);
      check("bubble_pc4", instr_pc_plus_4, 32'h0);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic do_cycle(input logic st, input logic rd, input logic [31:0] rpc);
    mreq_t m;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr >> 2;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    last_req = imem_req;
    if (rd) check("req_during_redirect", 32'(imem_req), 32'd0);
    if (imem_req && imem_gnt) begin
      m.addr  = imem_addr;
      m.ready = cyc + 1 + $urandom_range(lat_max, lat_min);
      if (mq.size() > 0 && mq[$].ready > m.ready) m.ready = mq[$].ready;
      mq.push_back(m);
      check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      check("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
    end
    if (imem_rvalid) void'(mq.pop_front());
    p_instr = instr; p_pc = instr_pc; p_pc4 = instr_pc_plus_4; p_valid = instr_valid;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor(st, rd, rpc);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do_cycle(1'b0, 1'b0, 32'h0);
    while (!instr_valid && n < 40) begin
      do_cycle(1'b0, 1'b0, 32'h0);
      n++;
    end
    check({tag, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
    check({tag, "_pc4"}, instr_pc_plus_4, 32'h0);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_addr"}, imem_addr, RST_PC);
  endtask

  initial begin
    int target;
    logic st, rd;
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_pc = RST_PC;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Zero-wait memory, no stall: one instruction per cycle from RESET_PC.
    do_cycle(1'b0, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) do_cycle(1'b0, 1'b0, 32'h0);
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc", instr_pc, RST_PC + 32'(4 * i));
      check("t1_instr", instr, 32'(i));
    end

    // Asynchronous reset between edges, mid-burst.
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk); @(negedge clk);
    mq.delete();
    exp_pc = RST_PC;
    reset  = 1'b0;

    // Restart, then stall for three cycles while pc 8 is shown.
    do_cycle(1'b0, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0);
    check("restart_pc", instr_pc, RST_PC);
    check("restart_valid", 32'(instr_valid), 32'd1);
    do_cycle(1'b0, 1'b0, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0);
    check("t2_pre_pc", instr_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 32'h0);
      check("t2_hold_pc", instr_pc, 32'h8);
    end
    check("t2_req_dropped", 32'(last_req), 32'd0);
    do_cycle(1'b0, 1'b0, 32'h0);
    check("t2_after_pc0", instr_pc, 32'hC);
    do_cycle(1'b0, 1'b0, 32'h0);
    check("t2_after_pc1", instr_pc, 32'h10);

    // Latency-3 memory: redirect with two requests outstanding.
    lat_min = 2; lat_max = 2;
    for (int n = 0; n < 20 && mq.size() < 2; n++) do_cycle(1'b0, 1'b0, 32'h0);
    check("t3_two_outstanding", 32'(mq.size()), 32'd2);
    do_cycle(1'b0, 1'b1, 32'h100);
    wait_valid("t3_first");
    check("t3_first_pc", instr_pc, 32'h100);
    wait_valid("t3_second");
    check("t3_second_pc", instr_pc, 32'h104);

    // Redirect together with stall clears outputs to a bubble.
    lat_min = 0; lat_max = 0;
    do_cycle(1'b1, 1'b1, 32'h200);
    check("t4_bubble_valid", 32'(instr_valid), 32'd0);
    check("t4_bubble_instr", instr, 32'h0);
    wait_valid("t4_resume");
    check("t4_resume_pc", instr_pc, 32'h200);

    // Random grant/response delays, stalls and redirects (including near-wrap targets).
    lat_min = 0; lat_max = 4; gnt_pct = 60;
    target = nvalid + 1000;
    for (int n = 0; n < 30000 && nvalid < target; n++) begin
      st  = ($urandom_range(99) < 20);
      rd  = ($urandom_range(99) < 2);
      rpc = ($urandom_range(99) < 20) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      do_cycle(st, rd, rpc);
    end
    check("random_progress", 32'(nvalid >= target), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
